// File: rtl/mat_cache_multi.sv
// Matrix cache: CACHE_SIZE square WIDTH x WIDTH matrices, one row/column/diagonal
// vector read and one masked vector write per cycle, plus a row-by-row CLEAR sequence.
module mat_cache_multi #(
    parameter int WIDTH      = 4,
    parameter int CACHE_SIZE = 4,
    parameter int DATA_WIDTH = 32,
    localparam int AW = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1,
    localparam int PW = $clog2(WIDTH)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  read_op,
    input  logic [AW-1:0]               read_addr,
    input  logic [PW-1:0]               read_param,
    output logic [WIDTH*DATA_WIDTH-1:0] data_out,
    output logic                        read_valid,
    input  logic [2:0]                  write_op,
    input  logic [AW-1:0]               write_addr,
    input  logic [PW-1:0]               write_param,
    input  logic [WIDTH-1:0]            write_mask,
    input  logic [WIDTH*DATA_WIDTH-1:0] data_in,
    output logic                        busy
);

    localparam logic [1:0] RD_NONE  = 2'd0;
    localparam logic [1:0] RD_ROW   = 2'd1;
    localparam logic [1:0] RD_COL   = 2'd2;
    localparam logic [1:0] RD_DIAG  = 2'd3;
    localparam logic [2:0] WR_ROW   = 3'd1;
    localparam logic [2:0] WR_COL   = 3'd2;
    localparam logic [2:0] WR_DIAG  = 3'd3;
    localparam logic [2:0] WR_CLEAR = 3'd4;

    localparam logic [AW:0]   NUM_MATS = (AW+1)'(CACHE_SIZE);
    localparam logic [PW-1:0] LAST_ROW = PW'(WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_CLEARING} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] clr_row_reg, clr_row_next;
    logic [AW-1:0] clr_addr_reg, clr_addr_next;
    logic          clr_en;

    logic [DATA_WIDTH-1:0]       cells [CACHE_SIZE][WIDTH][WIDTH];
    logic [WIDTH*DATA_WIDTH-1:0] rd_vec;
    logic                        wr_addr_ok;
    logic                        rd_addr_ok;
    logic                        wr_vec_en;

    // Non-power-of-two cache sizes leave addresses with no backing matrix.
    assign wr_addr_ok = ({1'b0, write_addr} < NUM_MATS);
    assign rd_addr_ok = ({1'b0, read_addr} < NUM_MATS);
    assign wr_vec_en  = (state_reg == ST_IDLE) && wr_addr_ok &&
                        ((write_op == WR_ROW) || (write_op == WR_COL) || (write_op == WR_DIAG));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            clr_row_reg  <= '0;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_row_reg  <= clr_row_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_row_next  = clr_row_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if ((write_op == WR_CLEAR) && wr_addr_ok) begin
                    state_next    = ST_CLEARING;
                    clr_row_next  = '0;
                    clr_addr_next = write_addr;
                end
            end
            ST_CLEARING: begin
                clr_row_next = clr_row_reg + PW'(1);
                if (clr_row_reg == LAST_ROW) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_reg == ST_CLEARING);
        clr_en = (state_reg == ST_CLEARING);
    end

    // Storage is one register per element so rows, columns and diagonals can all be
    // written in a single cycle; each cell works out which write lane (if any) targets it.
    for (genvar gm = 0; gm < CACHE_SIZE; gm++) begin : g_mat
        for (genvar gr = 0; gr < WIDTH; gr++) begin : g_row
            for (genvar gc = 0; gc < WIDTH; gc++) begin : g_col
                localparam logic [AW-1:0] M_IDX = AW'(gm);
                localparam logic [PW-1:0] R_IDX = PW'(gr);
                localparam logic [PW-1:0] C_IDX = PW'(gc);

                logic [DATA_WIDTH-1:0] cell_reg;
                logic                  hit;
                logic [PW-1:0]         lane;

                always_comb begin
                    hit  = 1'b0;
                    lane = C_IDX;
                    case (write_op)
                        WR_ROW: begin
                            hit  = (write_param == R_IDX);
                            lane = C_IDX;
                        end
                        WR_COL: begin
                            hit  = (write_param == C_IDX);
                            lane = R_IDX;
                        end
                        WR_DIAG: begin
                            hit  = (C_IDX == PW'(R_IDX + write_param));
                            lane = R_IDX;
                        end
                        default: ;
                    endcase
                end

                always_ff @(posedge clock) begin
                    if (!reset) begin
                        if (clr_en && (clr_addr_reg == M_IDX) && (clr_row_reg == R_IDX)) begin
                            cell_reg <= '0;
                        end else if (wr_vec_en && (write_addr == M_IDX) && hit && write_mask[lane]) begin
                            cell_reg <= data_in[lane*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end

                assign cells[gm][gr][gc] = cell_reg;
            end
        end
    end

    // Read lanes sample the cells before this edge's write, giving read-old on collisions.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rd
        localparam logic [PW-1:0] LANE = PW'(gi);

        logic [PW-1:0] rd_row;
        logic [PW-1:0] rd_col;

        always_comb begin
            rd_row = read_param;
            rd_col = LANE;
            case (read_op)
                RD_ROW: begin
                    rd_row = read_param;
                    rd_col = LANE;
                end
                RD_COL: begin
                    rd_row = LANE;
                    rd_col = read_param;
                end
                RD_DIAG: begin
                    rd_row = LANE;
                    rd_col = PW'(LANE + read_param);
                end
                default: ;
            endcase
        end

        assign rd_vec[gi*DATA_WIDTH +: DATA_WIDTH] =
            rd_addr_ok ? cells[read_addr][rd_row][rd_col] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_valid <= 1'b0;
            data_out   <= '0;
        end else if (read_op != RD_NONE) begin
            read_valid <= 1'b1;
            data_out   <= rd_vec;
        end else begin
            read_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mat_cache_multi.md
# mat_cache_multi

Parametrised matrix cache holding CACHE_SIZE square WIDTH×WIDTH matrices of fp32 bit patterns. It serves one vector read and one vector write per cycle. Vectors can be rows, columns or wrapped diagonals, writes take a per-element mask, and a multi-cycle clear operation is sequenced by an internal FSM. The block sits between the matrix unit's load/store path and the systolic datapath, and supersedes the row/diag-only cache.

## Interface
- WIDTH, 4: matrix dimension and vector length (≥2, power of two).
- CACHE_SIZE, 4: number of matrices held (≥1).
- DATA_WIDTH, 32: element width in bits (fp32 bit pattern, never interpreted).
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- read_op  in  2  0 NONE, 1 ROW, 2 COL, 3 DIAG.
- read_addr  in  $clog2(CACHE_SIZE)  matrix index.
- read_param  in  $clog2(WIDTH)  row, column or diagonal index.
- data_out  out  WIDTH×DATA_WIDTH  read vector, registered.
- read_valid  out  1  data_out holds the result of the previous cycle's read.
- write_op  in  3  0 NONE, 1 ROW, 2 COL, 3 DIAG, 4 CLEAR; 5–7 treated as NONE.
- write_addr  in  $clog2(CACHE_SIZE)  matrix index.
- write_param  in  $clog2(WIDTH)  row, column or diagonal index.
- write_mask  in  WIDTH  element i written only if write_mask[i]=1 (ignored for CLEAR).
- data_in  in  WIDTH×DATA_WIDTH  write vector.
- busy  out  1  CLEAR in progress; write ops are ignored while high.

## Operation
- Element addressing for matrix m, param p, lane i:
  - ROW: M[m][p][i].
  - COL: M[m][i][p].
  - DIAG: M[m][i][(i+p) mod WIDTH]; wrap is natural truncation of the index sum.
- Reads: any non-NONE read_op captures the addressed vector into data_out at the posedge, and read_valid=1 the next cycle.
  - NONE: read_valid=0 and data_out holds its last value.
- Writes (busy=0): ROW/COL/DIAG update the masked lanes at the posedge; unmasked lanes keep their value.
- CLEAR: FSM IDLE→CLEARING at the posedge where write_op=CLEAR and busy=0. Latches write_addr and row counter=0.
  - In CLEARING: row[counter] of the latched matrix is set to all zeros each cycle and counter increments.
  - After row WIDTH-1 is cleared, returns to IDLE.
- busy=1 exactly during CLEARING (WIDTH cycles). Write ops presented while busy=1 are dropped, not queued.
- Reads are always accepted, including during CLEARING. They see rows cleared in earlier cycles.
- Read/write collision in the same cycle on overlapping elements: the read returns pre-write contents (read-old). Same rule applies to the row being cleared that cycle.
- Out-of-range addr (≥CACHE_SIZE, non-power-of-two sizes): writes dropped, reads return zeros with read_valid=1.
- Storage is not reset; contents are undefined until written or cleared.

## Timing
- Reset values: read_valid=0, data_out=all zeros, busy=0, FSM=IDLE, counter=0.
- Read latency: 1 cycle (request at edge N, data valid after edge N+1 until edge N+2).
- Write visibility: a write at edge N is visible to a read issued for edge N+1.
- Back-to-back reads and writes sustain 1/cycle with no bubbles.
- CLEAR issued at edge N:
  - busy high after edge N until after edge N+WIDTH.
  - Row k is zero after edge N+1+k.
  - A new write is accepted at edge N+WIDTH+1.
- Reset asserted mid-CLEAR: FSM→IDLE and busy=0 next cycle. Rows not yet cleared keep old data. The pending write is dropped.
- Reset has priority over all ops in the same cycle.

## Test plan
- Row write then diag read:
  - Stimulus: WIDTH=4, matrix 0 rows {4,6,1,6},{1,2,3,4},{3,3,3,3},{9,7,5,3}; DIAG p=0..3.
  - Required: {4,2,3,3}, {6,3,3,9}, {1,4,3,7}, {6,1,3,5}; read_valid=1 one cycle after each request.
- Column write with mask:
  - Stimulus: COL p=2 data {10,11,12,13}, mask 4'b0101; then ROW read p=0 and p=1.
  - Required: M[0][2]=10, M[2][2]=12, M[1][2]=3 and M[3][2]=5 unchanged.
- Read/write collision:
  - Stimulus: ROW write p=1 {8,8,8,8} and ROW read p=1 in the same cycle.
  - Required: read returns {1,2,3,4}; the read on the next cycle returns {8,8,8,8}.
- CLEAR:
  - Stimulus: CLEAR on matrix 0 with a ROW write to matrix 1 issued one cycle later.
  - Required: busy high 4 cycles; all rows of matrix 0 zero afterwards; the matrix 1 write is dropped.
- Reset mid-CLEAR:
  - Stimulus: reset asserted 2 cycles into CLEAR.
  - Required: busy=0 and read_valid=0 the next cycle; rows 0–1 zero, rows 2–3 retain data.
- Parameter sweep:
  - Stimulus: WIDTH=8, CACHE_SIZE=3; write to addr 3, then read addr 3.
  - Required: the write is dropped; the read returns zeros with read_valid=1.
